// File: rtl/priority_arbiter_rr.sv
// ---------------------------------------------------------------------------
// priority_arbiter_rr
//
// Grants one of N requesters at a time and holds that grant until the
// grantee acknowledges (or, optionally, until a hold timeout expires).
// Selection is either fixed priority (highest index wins) or round-robin,
// where the most recent grantee drops to lowest priority.
//
// Parameters
//   N        number of request lines (2..32)
//   IDXW     index width, ceil(log2(N))
//   RR_MODE  0 = fixed priority, 1 = round-robin
//   MAX_HOLD grant-hold timeout in cycles (1..65535), 0 = no timeout
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   req      request vector, bit i = requester i
//   ack      current grantee done; only looked at while valid=1
//   gnt      registered one-hot grant vector (all zero when idle)
//   gnt_idx  registered binary index of the granted bit (0 when idle)
//   valid    registered, high while a grant is held
//   timeout  registered one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module priority_arbiter_rr #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int RR_MODE  = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            valid,
    output logic            timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value during the last permitted un-acked grant cycle.
    localparam logic [15:0] HOLD_LAST = (MAX_HOLD > 0) ? 16'(MAX_HOLD - 1) : 16'd0;

    state_t          state;
    state_t          state_n;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] ptr_n;
    logic [15:0]     hold_cnt;
    logic [15:0]     hold_cnt_n;
    logic [N-1:0]    gnt_n;
    logic [IDXW-1:0] gnt_idx_n;
    logic            valid_n;
    logic            timeout_n;

    logic [IDXW-1:0] sel_idx;
    logic            any_req;
    logic            hold_expired;
    logic            start_grant;
    logic            go_idle;

    // Highest set index of r; 0 when r is empty (caller checks any_req).
    function automatic logic [IDXW-1:0] pick_fixed(input logic [N-1:0] r);
        logic [IDXW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                s = IDXW'(i);
            end
        end
        return s;
    endfunction

    // Round-robin pick: search order is p-1, p-2, ..., 0, N-1, ..., p.
    // The loop visits candidates from lowest to highest priority, so the
    // last hit is the winner and no early-exit flag is needed.
    function automatic logic [IDXW-1:0] pick_rr(input logic [N-1:0] r,
                                                input logic [IDXW-1:0] p);
        logic [IDXW-1:0] s;
        int              pos;
        s = '0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(p) - k;
            if (pos < 0) begin
                pos = pos + N;
            end
            if (r[pos]) begin
                s = IDXW'(pos);
            end
        end
        return s;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign any_req      = |req;
    assign sel_idx      = (RR_MODE != 0) ? pick_rr(req, ptr) : pick_fixed(req);
    assign hold_expired = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        hold_cnt_n  = hold_cnt;
        gnt_n       = gnt;
        gnt_idx_n   = gnt_idx;
        valid_n     = valid;
        timeout_n   = 1'b0;
        start_grant = 1'b0;
        go_idle     = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    start_grant = 1'b1;
                end else begin
                    go_idle = 1'b1;
                end
            end
            GRANT: begin
                // ack wins over an expiring counter: that is a normal
                // release and must not raise timeout.
                if (ack || hold_expired) begin
                    timeout_n = ~ack;
                    if (any_req) begin
                        start_grant = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (MAX_HOLD > 0) begin
                    hold_cnt_n = hold_cnt + 16'd1;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (start_grant) begin
            state_n    = GRANT;
            gnt_n      = to_onehot(sel_idx);
            gnt_idx_n  = sel_idx;
            valid_n    = 1'b1;
            ptr_n      = sel_idx;
            hold_cnt_n = '0;
        end

        if (go_idle) begin
            state_n    = IDLE;
            gnt_n      = '0;
            gnt_idx_n  = '0;
            valid_n    = 1'b0;
            hold_cnt_n = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            gnt_idx  <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
            gnt      <= gnt_n;
            gnt_idx  <= gnt_idx_n;
            valid    <= valid_n;
            timeout  <= timeout_n;
        end
    end

    // Structural invariants of the grant outputs.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_matches_idx: assert property (@(posedge clk) disable iff (rst)
        valid |-> gnt[gnt_idx]);
    a_valid_iff_gnt: assert property (@(posedge clk) disable iff (rst)
        valid == (gnt != '0));

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// ---------------------------------------------------------------------------
// Bench for priority_arbiter_rr. Two instances share req/ack/rst:
//   dut_a : round-robin, MAX_HOLD=4
//   dut_b : fixed priority, no timeout
// ---------------------------------------------------------------------------
module tb_priority_arbiter_rr;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           ack;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt_a, gnt_b;
    logic [IDXW-1:0] idx_a, idx_b;
    logic           valid_a, valid_b;
    logic           to_a, to_b;

    int errors = 0;
    int checks = 0;

    priority_arbiter_rr #(.N(N), .IDXW(IDXW), .RR_MODE(1), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(gnt_a), .gnt_idx(idx_a), .valid(valid_a), .timeout(to_a)
    );

    priority_arbiter_rr #(.N(N), .IDXW(IDXW), .RR_MODE(0), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(gnt_b), .gnt_idx(idx_b), .valid(valid_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (one slot per instance) -------------
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];
    int m_held[2];
    int m_to[2];

    function automatic bit is_rr(int k);
        return (k == 0);
    endfunction

    function automatic int hold_lim(int k);
        return (k == 0) ? 4 : 0;
    endfunction

    // Fixed: largest set index. Round-robin: the set index closest below
    // ptr going downward with wrap, i.e. minimal (ptr-1-j) mod N.
    function automatic int pick(int k, logic [N-1:0] r, int p);
        int best;
        int bestd;
        int d;
        best  = 0;
        bestd = N + 1;
        for (int j = 0; j < N; j++) begin
            if (r[j]) begin
                if (!is_rr(k)) begin
                    best = j;
                end else begin
                    d = (p - 1 - j + 2 * N) % N;
                    if (d < bestd) begin
                        bestd = d;
                        best  = j;
                    end
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_held[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_grant(int k, logic [N-1:0] r);
        m_idx[k]   = pick(k, r, m_ptr[k]);
        m_ptr[k]   = m_idx[k];
        m_valid[k] = 1;
        m_held[k]  = 0;
    endtask

    task automatic model_step(int k, logic [N-1:0] r, logic a);
        bit forced;
        m_to[k] = 0;
        if (m_valid[k] == 0) begin
            if (r != 0) model_grant(k, r);
            else m_idx[k] = 0;
        end else begin
            forced = 1'b0;
            if (!a && hold_lim(k) > 0) begin
                m_held[k] = m_held[k] + 1;
                forced = (m_held[k] == hold_lim(k));
            end
            if (a || forced) begin
                m_to[k] = forced ? 1 : 0;
                if (r != 0) begin
                    model_grant(k, r);
                end else begin
                    m_valid[k] = 0;
                    m_idx[k]   = 0;
                end
            end
        end
    endtask

    // ---------------- helpers ---------------------------------------------
    function automatic logic [N-1:0] one_hot(int i);
        return 8'(1) << i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_dut(input string tag, input int k, input logic [N-1:0] eg,
                             input int eidx, input bit ev, input bit et);
        string nm;
        nm = (k == 0) ? "a" : "b";
        if (k == 0) begin
            check({tag, ".", nm, ".gnt"},     32'(gnt_a),   32'(eg));
            check({tag, ".", nm, ".idx"},     32'(idx_a),   32'(eidx));
            check({tag, ".", nm, ".valid"},   32'(valid_a), 32'(ev));
            check({tag, ".", nm, ".timeout"}, 32'(to_a),    32'(et));
        end else begin
            check({tag, ".", nm, ".gnt"},     32'(gnt_b),   32'(eg));
            check({tag, ".", nm, ".idx"},     32'(idx_b),   32'(eidx));
            check({tag, ".", nm, ".valid"},   32'(valid_b), 32'(ev));
            check({tag, ".", nm, ".timeout"}, 32'(to_b),    32'(et));
        end
    endtask

    task automatic check_model(input string tag, input int k);
        logic [N-1:0] eg;
        eg = (m_valid[k] != 0) ? one_hot(m_idx[k]) : '0;
        check_dut(tag, k, eg, m_idx[k], m_valid[k] != 0, m_to[k] != 0);
    endtask

    // One clock: model samples inputs at the edge, outputs checked 1 later.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) model_step(k, req, ack);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_dut("rst_async", 0, '0, 0, 1'b0, 1'b0);
        check_dut("rst_async", 1, '0, 0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table (dut_a) -----------------------
    typedef struct {
        logic [N-1:0] req;
        logic         ack;
        int           idx;
        bit           valid;
        bit           to;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // full request, ack every cycle: 7..0 then wrap to 7
        tbl[0]  = '{8'hFF, 1'b1, 7, 1'b1, 1'b0};
        tbl[1]  = '{8'hFF, 1'b1, 6, 1'b1, 1'b0};
        tbl[2]  = '{8'hFF, 1'b1, 5, 1'b1, 1'b0};
        tbl[3]  = '{8'hFF, 1'b1, 4, 1'b1, 1'b0};
        tbl[4]  = '{8'hFF, 1'b1, 3, 1'b1, 1'b0};
        tbl[5]  = '{8'hFF, 1'b1, 2, 1'b1, 1'b0};
        tbl[6]  = '{8'hFF, 1'b1, 1, 1'b1, 1'b0};
        tbl[7]  = '{8'hFF, 1'b1, 0, 1'b1, 1'b0};
        tbl[8]  = '{8'hFF, 1'b1, 7, 1'b1, 1'b0};
        // back-to-back to idx 2, then release with no requests
        tbl[9]  = '{8'h04, 1'b1, 2, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 1'b1, 0, 1'b0, 1'b0};
        tbl[11] = '{8'h00, 1'b1, 0, 1'b0, 1'b0};
        // ptr=2: req 0x09 picks 0; grantee drops req; forced release to idle
        tbl[12] = '{8'h09, 1'b0, 0, 1'b1, 1'b0};
        tbl[13] = '{8'h09, 1'b0, 0, 1'b1, 1'b0};
        tbl[14] = '{8'h00, 1'b0, 0, 1'b1, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 0, 1'b1, 1'b0};
        tbl[16] = '{8'h00, 1'b0, 0, 1'b0, 1'b1};
        tbl[17] = '{8'h00, 1'b0, 0, 1'b0, 1'b0};

        rst = 1'b1;
        req = 8'hFF;
        ack = 1'b0;
        model_reset();

        // reset holds outputs low before any clock edge, and across edges
        #2;
        check_dut("rst_noclk", 0, '0, 0, 1'b0, 1'b0);
        check_dut("rst_noclk", 1, '0, 0, 1'b0, 1'b0);
        step();
        step();
        check_dut("rst_edges", 0, '0, 0, 1'b0, 1'b0);
        check_dut("rst_edges", 1, '0, 0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            req = tbl[i].req;
            ack = tbl[i].ack;
            step();
            check_dut($sformatf("vec%0d", i), 0,
                      tbl[i].valid ? one_hot(tbl[i].idx) : 8'h00,
                      tbl[i].idx, tbl[i].valid, tbl[i].to);
            check_model($sformatf("vec%0d", i), 1);
        end

        // fixed priority picks 4 from 0x16 and holds while req moves
        do_reset();
        req = 8'b0001_0110;
        ack = 1'b0;
        step();
        check_dut("fixed_sel", 1, 8'h10, 4, 1'b1, 1'b0);
        req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            check_dut("fixed_hold", 1, 8'h10, 4, 1'b1, 1'b0);
            check_model("fixed_hold", 0);
        end
        ack = 1'b1;
        step();
        check_dut("fixed_next", 1, 8'h80, 7, 1'b1, 1'b0);

        // reset mid-grant abandons idx 5; afterwards ptr=0 so 7 wins
        do_reset();
        req = 8'h20;
        ack = 1'b0;
        step();
        check_dut("pre_rst", 0, 8'h20, 5, 1'b1, 1'b0);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check_dut("mid_rst", 0, '0, 0, 1'b0, 1'b0);
        check_dut("mid_rst", 1, '0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 8'h81;
        step();
        check_dut("post_rst", 0, 8'h80, 7, 1'b1, 1'b0);
        check_dut("post_rst", 1, 8'h80, 7, 1'b1, 1'b0);

        // timeout: idx 3 held 4 cycles, then forced to idx 0 with pulse
        do_reset();
        req = 8'h09;
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_dut($sformatf("hold%0d", i), 0, 8'h08, 3, 1'b1, 1'b0);
        end
        step();
        check_dut("tmo_pulse", 0, 8'h01, 0, 1'b1, 1'b1);
        step();
        check_dut("tmo_end", 0, 8'h01, 0, 1'b1, 1'b0);

        // ack on the expiring cycle is a normal release
        do_reset();
        req = 8'h09;
        ack = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_dut("pre_exp", 0, 8'h08, 3, 1'b1, 1'b0);
        ack = 1'b1;
        step();
        check_dut("ack_at_exp", 0, 8'h01, 0, 1'b1, 1'b0);
        ack = 1'b0;
        step();
        check_dut("after_exp", 0, 8'h01, 0, 1'b1, 1'b0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 8'($urandom);
                2: req = one_hot($urandom_range(0, 7));
                default: req = 8'($urandom & $urandom);
            endcase
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_model("rand_rst", 0);
                check_model("rand_rst", 1);
                rst = 1'b0;
            end
            step();
            check_model($sformatf("rand%0d", c), 0);
            check_model($sformatf("rand%0d", c), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
